// File: rtl/user_port_reg_read_bank.sv
// Read-only register bank behind the AXI-Lite read front-end user port.
// Serves ID, cycle counter, accepted-read counter and config-loaded scratch registers.
module user_port_reg_read_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 8,
    parameter int          READ_WAIT = 2,
    parameter logic [31:0] ID_VALUE  = 32'hA11E_0001,
    parameter int          IDX_W     = 3
) (
    input  logic             S_AXIL_ACLK,
    input  logic             S_AXIL_ARESET,
    input  logic             user_port_arvalid,
    output logic             user_port_arready,
    input  logic [31:0]      user_port_araddr,
    output logic             user_port_rvalid,
    output logic [31:0]      user_port_rdata,
    output logic [1:0]       user_port_rresp,
    input  logic             cfg_wr_en,
    input  logic [IDX_W-1:0] cfg_wr_idx,
    input  logic [31:0]      cfg_wr_data
);

    localparam logic [3:0]  WAIT_LOAD = 4'(READ_WAIT);
    localparam logic [31:0] NREGS     = 32'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic [31:0] addr_q;
    logic [31:0] addr_next;
    logic        arready_next;
    logic        rvalid_next;
    logic [31:0] rdata_next;
    logic [1:0]  rresp_next;

    logic [31:0] cycle_cnt;
    logic [31:0] read_cnt;
    logic [31:0] scratch [NUM_REGS];

    logic        accept;
    logic [31:0] offset;
    logic [31:0] word;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] reg_value;
    logic        cfg_hit;

    assign accept = (state == IDLE) && user_port_arvalid && user_port_arready;

    always_comb begin
        offset       = addr_q - BASE_ADDR;
        word         = offset >> 2;
        misaligned   = (addr_q[1:0] != 2'b00);
        out_of_range = (addr_q < BASE_ADDR) || (word >= NREGS);
        reg_value    = '0;
        if (!out_of_range) begin
            case (word)
                32'd0:   reg_value = ID_VALUE;
                32'd1:   reg_value = cycle_cnt;
                32'd2:   reg_value = read_cnt;
                default: reg_value = scratch[word[IDX_W-1:0]];
            endcase
        end
    end

    // RESP spans two cycles: the first ends on the sampling edge, the second
    // carries the rvalid pulse, keeping arready low until the pulse is over.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        addr_next     = addr_q;
        arready_next  = user_port_arready;
        rvalid_next   = 1'b0;
        rdata_next    = user_port_rdata;
        rresp_next    = user_port_rresp;
        case (state)
            IDLE: begin
                arready_next = 1'b1;
                if (accept) begin
                    addr_next     = user_port_araddr;
                    arready_next  = 1'b0;
                    wait_cnt_next = WAIT_LOAD;
                    state_next    = (READ_WAIT == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                arready_next  = 1'b0;
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                arready_next = 1'b0;
                if (!user_port_rvalid) begin
                    rvalid_next = 1'b1;
                    if (misaligned) begin
                        rresp_next = RESP_SLVERR;
                        rdata_next = '0;
                    end else if (out_of_range) begin
                        rresp_next = RESP_DECERR;
                        rdata_next = '0;
                    end else begin
                        rresp_next = RESP_OKAY;
                        rdata_next = reg_value;
                    end
                end else begin
                    state_next   = IDLE;
                    arready_next = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                arready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge S_AXIL_ACLK or posedge S_AXIL_ARESET) begin
        if (S_AXIL_ARESET) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            addr_q            <= '0;
            user_port_arready <= 1'b0;
            user_port_rvalid  <= 1'b0;
            user_port_rdata   <= '0;
            user_port_rresp   <= '0;
        end else begin
            state             <= state_next;
            wait_cnt          <= wait_cnt_next;
            addr_q            <= addr_next;
            user_port_arready <= arready_next;
            user_port_rvalid  <= rvalid_next;
            user_port_rdata   <= rdata_next;
            user_port_rresp   <= rresp_next;
        end
    end

    always_ff @(posedge S_AXIL_ACLK or posedge S_AXIL_ARESET) begin
        if (S_AXIL_ARESET) begin
            cycle_cnt <= '0;
            read_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (accept && (read_cnt != '1)) begin
                read_cnt <= read_cnt + 32'd1;
            end
        end
    end

    assign cfg_hit = cfg_wr_en && (32'(cfg_wr_idx) >= 32'd3) && (32'(cfg_wr_idx) < NREGS);

    always_ff @(posedge S_AXIL_ACLK or posedge S_AXIL_ARESET) begin
        if (S_AXIL_ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                scratch[i] <= '0;
            end
        end else if (cfg_hit) begin
            scratch[cfg_wr_idx] <= cfg_wr_data;
        end
    end

endmodule
